pic_stream: RTL and testbench
=============================

// Module: pic_stream
// PURPOSE
//  Streaming parallel-indices comparison unit for the sparse mat-mult datapath. Merges two
//  strictly increasing index streams (sparse row of A, sparse column of B) one vector at a time.
//  On every index match it buffers {idx, a_pos, b_pos} in a parametrised FIFO; the MAC stage
//  uses these entries to fetch the operand pair.
//  Adds over the single-pair comparator: valid/ready on all sides, no matches lost on FIFO full,
//  end-of-vector handling, per-vector match count.
// PARAMETERS
//  IDX_W   16  index width (A and B)
//  POS_W   16  element-position counter width (offset of element within its vector)
//  DEPTH   4   match FIFO entries; power of two, >=2
// PORTS
//  clk        in   1                   clock, all logic on posedge
//  rst        in   1                   synchronous, active-high reset
//  a_valid    in   1                   A index beat valid
//  a_idx      in   IDX_W               A index
//  a_last     in   1                   last A beat of current vector
//  a_ready    out  1                   A beat consumed this cycle (valid&ready)
//  b_valid, b_idx, b_last, b_ready     same as A, for B
//  m_valid    out  1                   match FIFO non-empty
//  m_ready    in   1                   downstream pops head when m_valid&m_ready
//  m_idx      out  IDX_W               head entry: matched index
//  m_a_pos    out  POS_W               head entry: position of match in A vector
//  m_b_pos    out  POS_W               head entry: position of match in B vector
//  fifo_count out  $clog2(DEPTH)+1     current FIFO occupancy
//  done       out  1                   1-cycle pulse: both vectors fully consumed
//  match_cnt  out  POS_W               matches in last completed vector; held until next done
// BEHAVIOUR
//  Reset: FIFO empty, m_valid=0, fifo_count=0, done=0, match_cnt=0, a_pos=b_pos=0, state=MERGE;
//   a_ready=b_ready=0 while rst=1. Reset mid-vector discards all buffered matches and progress.
//  FSM MERGE / DRAIN_A / DRAIN_B / DONE.
//  MERGE, both valid:
//   - a_idx<b_idx -> consume A only.
//   - a_idx>b_idx -> consume B only.
//   - equal -> consume both and push {a_idx,a_pos,b_pos}, only if can_push; else both readies stay 0.
//   - one side not valid -> no consume.
//  can_push = !full | pop. A push into a full FIFO is allowed only in the same cycle as a pop.
//  DRAIN_A: A beats are consumed unconditionally and discarded; B is ready=0.
//  DRAIN_B: mirror of DRAIN_A.
//  Transitions on consumed last beats:
//   - A last consumed in MERGE, B not finished -> DRAIN_B.
//   - B last consumed in MERGE, A not finished -> DRAIN_A.
//   - Both lasts consumed in the same cycle (equal or not) -> DONE.
//   - Last consumed while in DRAIN_x -> DONE.
//  DONE (one cycle): done=1, readies 0, match_cnt<=running count incl. any match pushed on
//   entry, running count/a_pos/b_pos cleared; then -> MERGE.
//  Position counters: a_pos increments per consumed A beat and wraps at 2^POS_W; b_pos likewise.
//  FIFO: first-word-fall-through. Head is visible on m_* in the cycle after the push (1-cycle latency).
//   Simultaneous push+pop leaves count unchanged. Pointers wrap mod DEPTH.
//   Pop on empty is ignored. Buffered matches persist across done; only rst flushes them.
//  a_ready/b_ready are combinational from valids, compare, state and can_push; no other path to them.
//  Input protocol: indices strictly increasing within a vector. Violations give undefined match
//   output but must never deadlock.
// STRUCTURE
//  pic_pkg:
//   - typedef pic_match_t packed struct {idx, a_pos, b_pos}
//   - typedef pic_state_e enum {MERGE, DRAIN_A, DRAIN_B, DONE}
//   - localparam defaults for IDX_W/POS_W
//  Sub-module pic_fifo #(DEPTH, type T=pic_match_t): sync FWFT FIFO with push/pop/full/empty/count.
//  Top level holds the compare, FSM and counters.
// TESTING
//  1 A={1,4,7,9} B={2,4,9}, m_ready=1 -> matches (4,1,1),(9,3,2); done once; match_cnt=2.
//  2 DEPTH=4, m_ready=0, A=B={0..5} -> 4 pushes, then a_ready=b_ready=0. Raise m_ready -> all 6
//    delivered in order, none lost.
//  3 Full FIFO + m_ready=1 + equal heads -> same-cycle push/pop, fifo_count stays 4.
//  4 A={3} last, B={1,5,8,12} last -> DRAIN_B consumes 5,8,12 with no pushes; done; match_cnt=0.
//  5 Both last beats equal (A={2,6}, B={6}) -> 1 push, direct MERGE->DONE, match_cnt=1.
//  6 rst asserted mid-vector with 3 entries buffered -> next cycle m_valid=0, fifo_count=0,
//    positions restart at 0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and default widths for the parallel-indices comparison stream.
package pic_pkg;

   localparam int unsigned PIC_IDX_W = 16;
   localparam int unsigned PIC_POS_W = 16;

   // One buffered match: the common index plus where it sat in each vector.
   typedef struct packed {
      logic [PIC_IDX_W-1:0] idx;
      logic [PIC_POS_W-1:0] a_pos;
      logic [PIC_POS_W-1:0] b_pos;
   } pic_match_t;

   // Merge both streams, drain the leftover of one side, or close the vector.
   typedef enum logic [1:0] {
      MERGE   = 2'd0,
      DRAIN_A = 2'd1,
      DRAIN_B = 2'd2,
      DONE    = 2'd3
   } pic_state_e;

endpackage

// File: rtl/pic_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is accepted
// only together with a pop; a pop on empty is ignored.
module pic_fifo
   import pic_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = pic_match_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  T                       i_data,
   input  logic                   i_pop,
   output T                       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("pic_fifo: DEPTH must be a power of two and at least 2");
   end

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (PW + 1)'(DEPTH));
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage write; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW + 1)'(1);
            2'b01:   r_count <= r_count - (PW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pic_stream.sv
// Streaming parallel-indices comparison: merges two strictly increasing index
// streams and buffers every index match with its position in each vector.
module pic_stream
   import pic_pkg::*;
#(
   parameter int unsigned IDX_W = PIC_IDX_W,
   parameter int unsigned POS_W = PIC_POS_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a_valid,
   input  logic [IDX_W-1:0]       a_idx,
   input  logic                   a_last,
   output logic                   a_ready,
   input  logic                   b_valid,
   input  logic [IDX_W-1:0]       b_idx,
   input  logic                   b_last,
   output logic                   b_ready,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [IDX_W-1:0]       m_idx,
   output logic [POS_W-1:0]       m_a_pos,
   output logic [POS_W-1:0]       m_b_pos,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   done,
   output logic [POS_W-1:0]       match_cnt
);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [POS_W-1:0] a_pos;
      logic [POS_W-1:0] b_pos;
   } match_t;

   pic_state_e       r_state;
   pic_state_e       w_state_nxt;
   logic [POS_W-1:0] r_a_pos;
   logic [POS_W-1:0] r_b_pos;
   logic [POS_W-1:0] r_run_cnt;
   logic [POS_W-1:0] r_match_cnt;

   logic   w_a_take;
   logic   w_b_take;
   logic   w_a_last_take;
   logic   w_b_last_take;
   logic   w_push;
   logic   w_pop;
   logic   w_full;
   logic   w_empty;
   logic   w_can_push;
   match_t w_push_data;
   match_t w_head;

   assign w_pop      = !w_empty && m_ready;
   // A full FIFO can still take the new match if the head leaves this cycle.
   assign w_can_push = !w_full || w_pop;

   assign w_push_data.idx   = a_idx;
   assign w_push_data.a_pos = r_a_pos;
   assign w_push_data.b_pos = r_b_pos;

   pic_fifo #(
      .DEPTH (DEPTH),
      .T     (match_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   // Compare heads and decide which beats are consumed and whether a match is pushed.
   always_comb begin
      w_a_take = 1'b0;
      w_b_take = 1'b0;
      w_push   = 1'b0;
      if (!rst) begin
         case (r_state)
            MERGE: begin
               if (a_valid && b_valid) begin
                  if (a_idx < b_idx) begin
                     w_a_take = 1'b1;
                  end else if (a_idx > b_idx) begin
                     w_b_take = 1'b1;
                  end else if (w_can_push) begin
                     // Equal heads stall as a pair rather than drop the match.
                     w_a_take = 1'b1;
                     w_b_take = 1'b1;
                     w_push   = 1'b1;
                  end
               end
            end
            DRAIN_A: w_a_take = a_valid;
            DRAIN_B: w_b_take = b_valid;
            default: ;
         endcase
      end
   end

   assign w_a_last_take = w_a_take && a_last;
   assign w_b_last_take = w_b_take && b_last;

   // Vector-level sequencing driven by which last beats have been consumed.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MERGE: begin
            if (w_a_last_take && w_b_last_take) begin
               w_state_nxt = DONE;
            end else if (w_a_last_take) begin
               w_state_nxt = DRAIN_B;
            end else if (w_b_last_take) begin
               w_state_nxt = DRAIN_A;
            end
         end
         DRAIN_A: if (w_a_last_take) w_state_nxt = DONE;
         DRAIN_B: if (w_b_last_take) w_state_nxt = DONE;
         DONE:    w_state_nxt = MERGE;
         default: w_state_nxt = MERGE;
      endcase
   end

   // State, element positions and the per-vector match tally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= MERGE;
         r_a_pos     <= '0;
         r_b_pos     <= '0;
         r_run_cnt   <= '0;
         r_match_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == DONE) begin
            // Any match pushed on the way into DONE is already in the tally.
            r_match_cnt <= r_run_cnt;
            r_run_cnt   <= '0;
            r_a_pos     <= '0;
            r_b_pos     <= '0;
         end else begin
            if (w_a_take) begin
               r_a_pos <= r_a_pos + POS_W'(1);
            end
            if (w_b_take) begin
               r_b_pos <= r_b_pos + POS_W'(1);
            end
            if (w_push) begin
               r_run_cnt <= r_run_cnt + POS_W'(1);
            end
         end
      end
   end

   assign a_ready   = w_a_take;
   assign b_ready   = w_b_take;
   assign m_valid   = !w_empty;
   assign m_idx     = w_head.idx;
   assign m_a_pos   = w_head.a_pos;
   assign m_b_pos   = w_head.b_pos;
   assign done      = (r_state == DONE);
   assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_pic_stream.sv
// Self-checking bench for pic_stream: directed scenarios plus random vectors,
// all checked against a set-intersection model of the two index streams.
module tb_pic_stream;

   localparam int unsigned IDX_W  = 16;
   localparam int unsigned POS_W  = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int          BUDGET = 2000;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   a_valid, b_valid, a_last, b_last, m_ready;
   logic [IDX_W-1:0]       a_idx, b_idx;
   logic                   a_ready, b_ready, m_valid, done;
   logic [IDX_W-1:0]       m_idx;
   logic [POS_W-1:0]       m_a_pos, m_b_pos, match_cnt;
   logic [$clog2(DEPTH):0] fifo_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pic_stream #(
      .IDX_W (IDX_W),
      .POS_W (POS_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_idx      (a_idx),
      .a_last     (a_last),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_idx      (b_idx),
      .b_last     (b_last),
      .b_ready    (b_ready),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_idx      (m_idx),
      .m_a_pos    (m_a_pos),
      .m_b_pos    (m_b_pos),
      .fifo_count (fifo_count),
      .done       (done),
      .match_cnt  (match_cnt)
   );

   // Drives one vector pair with vpct% valid and rpct% m_ready (m_ready held low for
   // the first 'stall' cycles) and compares everything against the intersection model.
   task automatic run_vector(input string name, input int aq[$], input int bq[$],
                             input int vpct, input int rpct, input int stall);
      int ei[$], ea[$], eb[$];
      int ai, bi, cyc, ndone, got_n, a_end, b_end, done_cyc, exp_done;
      for (int i = 0; i < aq.size(); i++) begin
         for (int j = 0; j < bq.size(); j++) begin
            if (aq[i] == bq[j]) begin
               ei.push_back(aq[i]);
               ea.push_back(i);
               eb.push_back(j);
            end
         end
      end
      ai = 0; bi = 0; cyc = 0; ndone = 0; got_n = 0;
      a_end = -1; b_end = -1; done_cyc = -1;
      while (cyc < BUDGET && !(ai == aq.size() && bi == bq.size() && ndone > 0 &&
                               got_n >= ei.size() && cyc > done_cyc + 1)) begin
         @(negedge clk);
         a_valid = (ai < aq.size()) && ($urandom_range(99) < vpct);
         a_idx   = (ai < aq.size()) ? IDX_W'(aq[ai]) : IDX_W'($urandom);
         a_last  = a_valid && (ai == aq.size() - 1);
         b_valid = (bi < bq.size()) && ($urandom_range(99) < vpct);
         b_idx   = (bi < bq.size()) ? IDX_W'(bq[bi]) : IDX_W'($urandom);
         b_last  = b_valid && (bi == bq.size() - 1);
         m_ready = (cyc >= stall) && ($urandom_range(99) < rpct);
         #1;
         if (stall > 0 && cyc == stall - 1) begin
            n_total++;
            if (fifo_count !== (DEPTH + 1)'(DEPTH) || a_ready !== 1'b0 || b_ready !== 1'b0)
               $display("FAIL %s full_stall: count=%0d a_ready=%b b_ready=%b, want %0d/0/0",
                        name, fifo_count, a_ready, b_ready, DEPTH);
            else n_pass++;
         end
         if (stall > 0 && cyc == stall) begin
            n_total++;
            if (fifo_count !== (DEPTH + 1)'(DEPTH) || a_ready !== 1'b1 || b_ready !== 1'b1)
               $display("FAIL %s push_pop_full: count=%0d a_ready=%b b_ready=%b, want %0d/1/1",
                        name, fifo_count, a_ready, b_ready, DEPTH);
            else n_pass++;
         end
         if (stall > 0 && cyc == stall + 1) begin
            n_total++;
            if (fifo_count !== (DEPTH + 1)'(DEPTH))
               $display("FAIL %s count_after_push_pop: got %0d want %0d", name, fifo_count,
                        DEPTH);
            else n_pass++;
         end
         if (a_ready) begin
            n_total++;
            if (!a_valid) $display("FAIL %s a_ready_no_valid: a_ready=1 want 0", name);
            else n_pass++;
            if (ai == aq.size() - 1) a_end = cyc;
            ai++;
         end
         if (b_ready) begin
            n_total++;
            if (!b_valid) $display("FAIL %s b_ready_no_valid: b_ready=1 want 0", name);
            else n_pass++;
            if (bi == bq.size() - 1) b_end = cyc;
            bi++;
         end
         if (m_valid && m_ready) begin
            n_total++;
            if (got_n >= ei.size())
               $display("FAIL %s extra_match: got (%0d,%0d,%0d) want none", name, m_idx,
                        m_a_pos, m_b_pos);
            else if (m_idx !== IDX_W'(ei[got_n]) || m_a_pos !== POS_W'(ea[got_n]) ||
                     m_b_pos !== POS_W'(eb[got_n]))
               $display("FAIL %s match%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, got_n,
                        m_idx, m_a_pos, m_b_pos, ei[got_n], ea[got_n], eb[got_n]);
            else n_pass++;
            got_n++;
         end
         if (done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            n_total++;
            if (match_cnt !== POS_W'(ei.size()))
               $display("FAIL %s match_cnt: got %0d want %0d", name, match_cnt, ei.size());
            else n_pass++;
         end
         cyc++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      exp_done = ((a_end > b_end) ? a_end : b_end) + 1;
      n_total++;
      if (cyc >= BUDGET) $display("FAIL %s timeout: ran %0d cycles, limit %0d", name, cyc, BUDGET);
      else n_pass++;
      n_total++;
      if (ndone != 1) $display("FAIL %s done_count: got %0d want 1", name, ndone);
      else n_pass++;
      n_total++;
      if (got_n != ei.size()) $display("FAIL %s matches: got %0d want %0d", name, got_n, ei.size());
      else n_pass++;
      n_total++;
      if (done_cyc != exp_done)
         $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, exp_done);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1; a_idx = 16'd5; b_idx = 16'd5;
      a_last = 1'b0; b_last = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if (m_valid !== 1'b0 || fifo_count !== '0 || done !== 1'b0 || match_cnt !== '0)
         $display("FAIL reset_outputs: m_valid=%b count=%0d done=%b match_cnt=%0d want 0/0/0/0",
                  m_valid, fifo_count, done, match_cnt);
      else n_pass++;
      n_total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
         $display("FAIL reset_ready: a_ready=%b b_ready=%b want 0/0", a_ready, b_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_basic();
      int qa[$];
      int qb[$];
      qa = '{1, 4, 7, 9};
      qb = '{2, 4, 9};
      run_vector("basic", qa, qb, 100, 100, 0);
   endtask

   task automatic test_backpressure();
      int qa[$];
      int qb[$];
      qa = '{0, 1, 2, 3, 4, 5};
      qb = '{0, 1, 2, 3, 4, 5};
      run_vector("backpressure", qa, qb, 100, 100, 8);
   endtask

   task automatic test_drain();
      int qa[$];
      int qb[$];
      qa = '{3};
      qb = '{1, 5, 8, 12};
      run_vector("drain_b", qa, qb, 100, 100, 0);
      qa = '{0, 2, 10, 11, 20};
      qb = '{2, 4};
      run_vector("drain_a", qa, qb, 70, 60, 0);
   endtask

   task automatic test_both_last();
      int qa[$];
      int qb[$];
      qa = '{2, 6};
      qb = '{6};
      run_vector("both_last", qa, qb, 100, 100, 0);
   endtask

   task automatic test_reset_mid();
      int qa[$];
      int qb[$];
      @(negedge clk);
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_valid = 1'b1; b_valid = 1'b1; a_idx = IDX_W'(k); b_idx = IDX_W'(k);
         a_last = 1'b0; b_last = 1'b0;
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      n_total++;
      if (fifo_count !== 3'd3 || m_valid !== 1'b1)
         $display("FAIL mid_buffered: count=%0d m_valid=%b want 3/1", fifo_count, m_valid);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if (m_valid !== 1'b0 || fifo_count !== '0 || match_cnt !== '0)
         $display("FAIL mid_reset_flush: m_valid=%b count=%0d match_cnt=%0d want 0/0/0",
                  m_valid, fifo_count, match_cnt);
      else n_pass++;
      rst = 1'b0;
      qa = '{5, 7};
      qb = '{7};
      run_vector("after_reset", qa, qb, 100, 100, 0);
   endtask

   task automatic test_random();
      int qa[$];
      int qb[$];
      int v;
      for (int n = 0; n < 25; n++) begin
         qa.delete();
         qb.delete();
         v = $urandom_range(0, 3);
         for (int k = 0; k < $urandom_range(1, 8); k++) begin
            qa.push_back(v);
            v += $urandom_range(1, 3);
         end
         v = $urandom_range(0, 3);
         for (int k = 0; k < $urandom_range(1, 8); k++) begin
            qb.push_back(v);
            v += $urandom_range(1, 3);
         end
         run_vector($sformatf("random%0d", n), qa, qb, $urandom_range(30, 100),
                    $urandom_range(20, 100), 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_drain();
      test_both_last();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
